shift_sequencer: RTL and testbench

//  Multi-cycle controller that sequences one power-of-two shift level per clock to

---
 rtl/shift_sequencer.sv | 173 +++++++++++++++++
 tb/tb_shift_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shift_sequencer                                              |
// | Description : Multi-cycle logical left/right shifter. One power-of-two     |
// |               shift level is applied per clock, MSB level first, so the    |
// |               ALU only needs a single shift stage instead of a full        |
// |               barrel shifter.                                              |
// | Option macro: SHIFT_SRA_EN - adds the arith port; right shifts with        |
// |               arith=1 fill vacated bits with the captured operand MSB.     |
// |               Undefined: every right shift is logical (zero fill).         |
// | Ports       : clk    - rising-edge clock                                   |
// |               reset  - synchronous, active-high reset                      |
// |               start  - request, sampled only while busy=0                  |
// |               A      - operand, captured on an accepted start              |
// |               shamt  - shift amount, captured on an accepted start         |
// |               dir    - 0 = left, 1 = right, captured on an accepted start  |
// |               arith  - arithmetic right shift (SHIFT_SRA_EN only)          |
// |               busy   - high while levels are being applied                 |
// |               done   - one-cycle pulse, M valid in that cycle              |
// |               M      - result register, holds until next accepted start    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [SHW-1:0]   shamt,
   input  logic             dir,
`ifdef SHIFT_SRA_EN
   input  logic             arith,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] M
);

   // Level index counts SHW-1 down to 0; needs enough bits to hold SHW-1.
   localparam int c_IDX_W = (SHW > 1) ? $clog2(SHW) : 1;
   localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(SHW - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [c_IDX_W-1:0] idx_q, idx_d;
   logic [SHW-1:0]     shamt_q, shamt_d;
   logic               dir_q, dir_d;
`ifdef SHIFT_SRA_EN
   logic               arith_q, arith_d;
   logic               sign_q, sign_d;
`endif

   logic               w_accept;
   logic               w_fill;
   logic [WIDTH-1:0]   w_level_out;
   logic [WIDTH-1:0]   w_lvl_left  [SHW];
   logic [WIDTH-1:0]   w_lvl_right [SHW];

   // A new request is taken in IDLE and also in DONE, which allows
   // back-to-back operations without a dead cycle.
   assign w_accept = start && (state_q != S_SHIFT);

   // Fill bit for right shifts. The sign is taken from the operand as it was
   // captured, not from the live input.
`ifdef SHIFT_SRA_EN
   assign w_fill = arith_q & sign_q;
`else
   assign w_fill = 1'b0;
`endif

   // Each level is a fixed-distance shift; only the selected one is used,
   // so every candidate is just rewiring plus a single mux.
   for (genvar k = 0; k < SHW; k++) begin : g_level
      localparam int c_DIST = 2 ** k;
      assign w_lvl_left[k]  = {m_q[WIDTH-1-c_DIST:0], {c_DIST{1'b0}}};
      assign w_lvl_right[k] = {{c_DIST{w_fill}}, m_q[WIDTH-1:c_DIST]};
   end

   assign w_level_out = dir_q ? w_lvl_right[idx_q] : w_lvl_left[idx_q];

   // ---------------------------------------------------------------------
   // Next-state and datapath update
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      idx_d   = idx_q;
      shamt_d = shamt_q;
      dir_d   = dir_q;
`ifdef SHIFT_SRA_EN
      arith_d = arith_q;
      sign_d  = sign_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               m_d     = A;
               shamt_d = shamt;
               dir_d   = dir;
               idx_d   = c_IDX_TOP;
`ifdef SHIFT_SRA_EN
               arith_d = arith;
               sign_d  = A[WIDTH-1];
`endif
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_SHIFT: begin
            // Every level takes one cycle whether or not its bit is set,
            // which keeps latency independent of the shift amount.
            if (shamt_q[idx_q]) begin
               m_d = w_level_out;
            end
            if (idx_q == '0) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q - c_IDX_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers; reset overrides any operation in flight
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         idx_q   <= c_IDX_TOP;
         shamt_q <= '0;
         dir_q   <= 1'b0;
`ifdef SHIFT_SRA_EN
         arith_q <= 1'b0;
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         idx_q   <= idx_d;
         shamt_q <= shamt_d;
         dir_q   <= dir_d;
`ifdef SHIFT_SRA_EN
         arith_q <= arith_d;
         sign_q  <= sign_d;
`endif
      end
   end

   // Status flags decode directly from the state register, so busy and done
   // can never be high together.
   assign busy = (state_q == S_SHIFT);
   assign done = (state_q == S_DONE);
   assign M    = m_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_shift_sequencer                                           |
// | Description : Self-checking bench for shift_sequencer. A transaction-level |
// |               model predicts busy/done/M each cycle from the age of the    |
// |               current operation and a plain-arithmetic shift result.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_shift_sequencer;

   localparam int WIDTH = 32;
   localparam int SHW   = 5;
   localparam int LAT   = SHW + 1;   // accept edge to done cycle

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [SHW-1:0]   shamt;
   logic             dir;
   logic             arith;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] M;

   int total = 0;
   int bad   = 0;

   shift_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .shamt (shamt),
      .dir   (dir),
`ifdef SHIFT_SRA_EN
      .arith (arith),
`endif
      .busy  (busy),
      .done  (done),
      .M     (M)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference result straight from the definition of a shift.
   function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] a, input logic [SHW-1:0] s,
                                                 input logic d, input logic ar);
      logic sra;
      sra = 1'b0;
`ifdef SHIFT_SRA_EN
      sra = ar;
`endif
      if (!d)  return a << s;
      if (sra) return $signed(a) >>> s;
      return a >> s;
   endfunction

   // ---------------------------------------------------------------------
   // Model: tracks the age (cycles since acceptance) of the current op
   // ---------------------------------------------------------------------
   logic             mdl_valid = 1'b0;
   logic             mdl_active = 1'b0;
   int               mdl_age = 0;
   logic [WIDTH-1:0] mdl_res = '0;
   logic [WIDTH-1:0] mdl_m = '0;

   always @(posedge clk) begin
      if (reset) begin
         mdl_valid  <= 1'b1;
         mdl_active <= 1'b0;
         mdl_age    <= 0;
         mdl_m      <= '0;
      end else if (mdl_valid) begin
         if (start && !(mdl_active && mdl_age < LAT)) begin
            mdl_active <= 1'b1;
            mdl_age    <= 1;
            mdl_res    <= ref_shift(A, shamt, dir, arith);
         end else if (mdl_active) begin
            mdl_age <= mdl_age + 1;
            if (mdl_age + 1 == LAT) mdl_m <= mdl_res;
            if (mdl_age >= LAT) mdl_active <= 1'b0;
         end
      end
   end

   // Compare process: outputs sampled on the falling edge
   always @(negedge clk) begin
      if (mdl_valid) begin
         chk("busy", {31'd0, busy}, {31'd0, (mdl_active && mdl_age < LAT)});
         chk("done", {31'd0, done}, {31'd0, (mdl_active && mdl_age == LAT)});
         if (!(mdl_active && mdl_age < LAT)) chk("M", M, mdl_m);
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_done(input int n0, output int lat);
      lat = n0;
      while (done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      if (done !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done after %0d cycles required done at %0d", lat, LAT);
      end
   endtask

   // Issue one op from IDLE or DONE, scramble inputs after capture,
   // then check latency and result against a literal expectation.
   task automatic do_op(input string name, input logic [WIDTH-1:0] a, input logic [SHW-1:0] s,
                        input logic d, input logic ar, input logic [WIDTH-1:0] exp);
      int lat;
      A = a; shamt = s; dir = d; arith = ar; start = 1'b1;
      tick();
      start = 1'b0;
      A = $urandom; shamt = SHW'($urandom_range(0, 31)); dir = ~d; arith = ~ar;
      wait_done(1, lat);
      chk({name, "_lat"}, WIDTH'(lat), WIDTH'(LAT));
      chk({name, "_M"}, M, exp);
   endtask

   initial begin
      int lat;
      reset = 1'b1; start = 1'b0; A = '0; shamt = '0; dir = 1'b0; arith = 1'b0;

      // Model pinned to hand-computed values
      chk("ref_sll8",  ref_shift(32'h0000_0001, 5'd8, 1'b0, 1'b0), 32'h0000_0100);
      chk("ref_srl31", ref_shift(32'h8000_0000, 5'd31, 1'b1, 1'b0), 32'h0000_0001);
      chk("ref_sll4",  ref_shift(32'hFFFF_FFFF, 5'd4, 1'b0, 1'b0), 32'hFFFF_FFF0);

      repeat (3) tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_M", M, 32'd0);
      reset = 1'b0;
      tick();

      // Basic ops, boundaries and back-to-back issue from DONE
      do_op("sll8",  32'h0000_0001, 5'd8,  1'b0, 1'b0, 32'h0000_0100);
      do_op("srl31", 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001);
      do_op("sll4",  32'hFFFF_FFFF, 5'd4,  1'b0, 1'b0, 32'hFFFF_FFF0);
      do_op("sh0",   32'h1234_5678, 5'd0,  1'b1, 1'b0, 32'h1234_5678);
      do_op("sll31", 32'h0000_0003, 5'd31, 1'b0, 1'b0, 32'h8000_0000);
      tick();

      // Start while busy is ignored; start held in DONE is accepted
      A = 32'h0000_0001; shamt = 5'd8; dir = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      A = 32'hFFFF_FFFF; shamt = 5'd3; dir = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(3, lat);
      chk("ign_lat", WIDTH'(lat), WIDTH'(LAT));
      chk("ign_M", M, 32'h0000_0100);
      do_op("b2b", 32'h0000_000F, 5'd4, 1'b0, 1'b0, 32'h0000_00F0);
      tick();

      // Reset in the middle of an operation
      A = 32'h0000_0055; shamt = 5'd1; dir = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_M", M, 32'd0);
      for (int i = 0; i < LAT + 1; i++) begin
         tick();
         chk("abort_nodone", {31'd0, done}, 32'd0);
      end
      do_op("after_rst", 32'hA5A5_0000, 5'd16, 1'b1, 1'b0, 32'h0000_A5A5);

      // Right shift of a negative operand with and without arith
`ifdef SHIFT_SRA_EN
      do_op("sra4", 32'h8000_0000, 5'd4, 1'b1, 1'b1, 32'hF800_0000);
`else
      do_op("sra4", 32'h8000_0000, 5'd4, 1'b1, 1'b1, 32'h0800_0000);
`endif
      do_op("srl4", 32'h8000_0000, 5'd4, 1'b1, 1'b0, 32'h0800_0000);

      // Random traffic, checked cycle by cycle by the compare process
      for (int i = 0; i < 600; i++) begin
         tick();
         reset = ($urandom_range(0, 63) == 0);
         start = ($urandom_range(0, 2) == 0);
         A     = $urandom;
         case ($urandom_range(0, 7))
            0:       shamt = '0;
            1:       shamt = '1;
            default: shamt = SHW'($urandom_range(0, 31));
         endcase
         dir   = 1'($urandom_range(0, 1));
         arith = 1'($urandom_range(0, 1));
      end
      reset = 1'b0;
      start = 1'b0;
      repeat (LAT + 2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
